risc_reg_file: RTL and testbench
================================

# risc_reg_file

Eight-entry, 8-bit register file for the RISC datapath. It provides two independent combinational read ports that supply ALU operands A and B. Its single synchronous write port takes either the ALU result or the data-memory load value, selected by `load_op`. All eight registers are also exported directly for debug and observation.

## Interface
Parameters:
- `DATA_W`, 8, register width.
- `ADDR_W`, 3, address width; depth = 2**ADDR_W = 8.

Ports:
- `clk`, input, 1, single clock; all state updates on the rising edge.
- `rst_n`, input, 1, reset. Port name follows the codebase; the signal is asynchronous and active-high (asserted = 1).
- `opnda_addr`, input, 3, operand A read address.
- `opndb_addr`, input, 3, operand B read address.
- `dst`, input, 3, write destination address.
- `reg_wr_vld`, input, 1, write enable.
- `load_op`, input, 1, write-data select: 1 = `dmdataout`, 0 = `rslt`.
- `rslt`, input, 8, ALU result.
- `dmdataout`, input, 8, data-memory read data.
- `oprnd_a`, output, 8, contents of register[`opnda_addr`].
- `oprnd_b`, output, 8, contents of register[`opndb_addr`].
- `regfile0` … `regfile7`, output, 8 each, direct register contents.

## Operation
- Storage is 8 × 8-bit registers, all writable, including register 0 (no hardwired zero).
- Reset (`rst_n` = 1) loads the registers asynchronously:
  - r0=00, r1=22, r2=44, r3=66
  - r4=88, r5=AA, r6=CC, r7=FF
- While reset is held, writes are ignored.
- Write data is `wdata = load_op ? dmdataout : rslt`.
- Write: on the rising `clk` edge with `reg_wr_vld`=1 and reset deasserted, register[`dst`] ← `wdata`.
  - Only that one register changes.
  - With `reg_wr_vld`=0, all registers hold.
  - `load_op`, `rslt` and `dmdataout` are don't-care when `reg_wr_vld`=0.
- Reads are purely combinational: `oprnd_a`/`oprnd_b` follow address changes with no clock.
  - Both ports may address the same register.
- `regfileN` outputs are the register flops themselves.
- All addresses are fully decoded; there are no out-of-range cases.

## Timing
- Write latency: 1 edge. The value is visible on `regfileN` and on any read port addressing it right after the rising edge.
- Read-during-write to the same address: the read port shows the old value until the edge and the new value after it. There is no write-through bypass.
- Reset asserted mid-cycle:
  - All outputs take their reset values immediately, independent of `clk`.
  - A write pending in that cycle is lost.
- Reset deassertion: the first write can occur on the next rising edge.
- Outputs after reset:
  - `oprnd_a`/`oprnd_b` equal the reset contents of the addressed registers.
  - `regfile0..7` equal the reset table.

## Structure
- Shared package `risc_pkg`:
  - `DATA_W` and `ADDR_W` constants.
  - An 8-entry reset-value constant array.
  - A `reg_addr_t` typedef.
- Natural sub-module `risc_reg_wr_sel`: the 2:1 write-data mux plus the `dst` one-hot decode, producing per-register enables.
- The top level holds the flop array, both read muxes, and the debug outputs.

## Test plan
- Reset then read:
  - Assert `rst_n`=1, then release.
  - Addresses (0,1) → `oprnd_a`=00, `oprnd_b`=22.
  - Addresses (2,3) → 44/66; (4,5) → 88/AA; (6,7) → CC/FF.
- ALU writes:
  - `load_op`=0, `reg_wr_vld`=1.
  - `dst`=0/2/4/6 with `rslt`=00/22/44/66, `dmdataout`=00.
  - After each edge the addressed `regfileN` equals `rslt`; other registers are unchanged.
- Load writes:
  - `load_op`=1.
  - `dst`=1/3/5/7 with `dmdataout`=11/33/55/77, `rslt`=00.
  - `regfile1`=11, `regfile3`=33, `regfile5`=55, `regfile7`=77.
- Write disabled:
  - `reg_wr_vld`=0, `dst`=4, `rslt`=5A.
  - `regfile4` is unchanged across several edges.
- Read/write collision:
  - `opnda_addr`=`dst`=3, write `rslt`=9C.
  - Before the edge `oprnd_a` shows the old value; after the edge it shows 9C.
  - `oprnd_b` addressing 3 at the same time shows the same.
- Async reset mid-operation:
  - Write F0 to r5, then assert reset between clock edges.
  - `regfile5` immediately returns to AA and the remaining registers return to the reset table.
  - A write presented during reset does not occur.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared constants and types for the RISC register file.
package risc_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  // Index [0] is the rightmost element: r0=00 ... r7=FF.
  localparam logic [NUM_REGS-1:0][DATA_W-1:0] REG_RST_VAL = {
    8'hFF, 8'hCC, 8'hAA, 8'h88,
    8'h66, 8'h44, 8'h22, 8'h00
  };

endpackage

// File: rtl/risc_reg_wr_sel.sv
// Write-side selection: picks ALU result or load data and decodes dst into
// one-hot per-register write enables.
module risc_reg_wr_sel
  import risc_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int ADDR_W_P = ADDR_W
) (
  input  logic [ADDR_W_P-1:0]      dst,
  input  logic                     reg_wr_vld,
  input  logic                     load_op,
  input  logic [DATA_W_P-1:0]      rslt,
  input  logic [DATA_W_P-1:0]      dmdataout,
  output logic [DATA_W_P-1:0]      wdata,
  output logic [2**ADDR_W_P-1:0]   wr_en
);

  assign wdata = load_op ? dmdataout : rslt;

  // One-hot decode of the destination, gated by the write enable.
  always_comb begin
    wr_en      = '0;
    wr_en[dst] = reg_wr_vld;
  end

endmodule

// File: rtl/risc_reg_file.sv
// Eight-entry register file: one synchronous write port, two combinational
// read ports, and every register exported for debug.
module risc_reg_file
  import risc_pkg::*;
#(
  parameter int DATA_W = risc_pkg::DATA_W,
  parameter int ADDR_W = risc_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,      // active-high async reset despite the name
  input  logic [ADDR_W-1:0] opnda_addr,
  input  logic [ADDR_W-1:0] opndb_addr,
  input  logic [ADDR_W-1:0] dst,
  input  logic              reg_wr_vld,
  input  logic              load_op,
  input  logic [DATA_W-1:0] rslt,
  input  logic [DATA_W-1:0] dmdataout,
  output logic [DATA_W-1:0] oprnd_a,
  output logic [DATA_W-1:0] oprnd_b,
  output logic [DATA_W-1:0] regfile0,
  output logic [DATA_W-1:0] regfile1,
  output logic [DATA_W-1:0] regfile2,
  output logic [DATA_W-1:0] regfile3,
  output logic [DATA_W-1:0] regfile4,
  output logic [DATA_W-1:0] regfile5,
  output logic [DATA_W-1:0] regfile6,
  output logic [DATA_W-1:0] regfile7
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DATA_W-1:0] w_wdata;
  logic [DEPTH-1:0]  w_wr_en;

  risc_reg_wr_sel #(
    .DATA_W_P (DATA_W),
    .ADDR_W_P (ADDR_W)
  ) u_wr_sel (
    .dst        (dst),
    .reg_wr_vld (reg_wr_vld),
    .load_op    (load_op),
    .rslt       (rslt),
    .dmdataout  (dmdataout),
    .wdata      (w_wdata),
    .wr_en      (w_wr_en)
  );

  // Register array: async load of the reset table, otherwise per-entry write.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= REG_RST_VAL[i];
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr_en[i]) begin
          r_regs[i] <= w_wdata;
        end
      end
    end
  end

  // No write-through bypass: reads see the flop contents only.
  assign oprnd_a = r_regs[opnda_addr];
  assign oprnd_b = r_regs[opndb_addr];

  assign regfile0 = r_regs[0];
  assign regfile1 = r_regs[1];
  assign regfile2 = r_regs[2];
  assign regfile3 = r_regs[3];
  assign regfile4 = r_regs[4];
  assign regfile5 = r_regs[5];
  assign regfile6 = r_regs[6];
  assign regfile7 = r_regs[7];

endmodule

// File: tb/tb_risc_reg_file.sv
// Directed self-checking bench for risc_reg_file.
module tb_risc_reg_file;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] opnda_addr, opndb_addr, dst;
  logic       reg_wr_vld, load_op;
  logic [7:0] rslt, dmdataout;
  logic [7:0] oprnd_a, oprnd_b;
  logic [7:0] regfile0, regfile1, regfile2, regfile3;
  logic [7:0] regfile4, regfile5, regfile6, regfile7;

  logic [7:0] rf     [8];
  logic [7:0] exp_rf [8];
  logic [7:0] rst_tbl [8];

  int n_checks = 0;
  int n_fail   = 0;

  risc_reg_file dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opnda_addr (opnda_addr),
    .opndb_addr (opndb_addr),
    .dst        (dst),
    .reg_wr_vld (reg_wr_vld),
    .load_op    (load_op),
    .rslt       (rslt),
    .dmdataout  (dmdataout),
    .oprnd_a    (oprnd_a),
    .oprnd_b    (oprnd_b),
    .regfile0   (regfile0),
    .regfile1   (regfile1),
    .regfile2   (regfile2),
    .regfile3   (regfile3),
    .regfile4   (regfile4),
    .regfile5   (regfile5),
    .regfile6   (regfile6),
    .regfile7   (regfile7)
  );

  always #5 clk = ~clk;

  assign rf[0] = regfile0;
  assign rf[1] = regfile1;
  assign rf[2] = regfile2;
  assign rf[3] = regfile3;
  assign rf[4] = regfile4;
  assign rf[5] = regfile5;
  assign rf[6] = regfile6;
  assign rf[7] = regfile7;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_r%0d", tag, i), rf[i], exp_rf[i]);
    end
  endtask

  task automatic chk_read(input logic [2:0] a, input logic [2:0] b, input string tag);
    opnda_addr = a;
    opndb_addr = b;
    #1;
    chk({tag, "_a"}, oprnd_a, exp_rf[a]);
    chk({tag, "_b"}, oprnd_b, exp_rf[b]);
  endtask

  // Present a write at the falling edge, let one rising edge pass, sample 1 later.
  task automatic do_write(input logic ld, input logic [2:0] d,
                          input logic [7:0] r, input logic [7:0] m);
    @(negedge clk);
    reg_wr_vld = 1'b1;
    load_op    = ld;
    dst        = d;
    rslt       = r;
    dmdataout  = m;
    @(posedge clk);
    #1;
    reg_wr_vld = 1'b0;
  endtask

  initial begin
    rst_tbl = '{8'h00, 8'h22, 8'h44, 8'h66, 8'h88, 8'hAA, 8'hCC, 8'hFF};
    exp_rf  = rst_tbl;

    // Reset held with a write presented: the write must be ignored.
    rst_n      = 1'b1;
    opnda_addr = 3'd0;
    opndb_addr = 3'd1;
    dst        = 3'd0;
    reg_wr_vld = 1'b1;
    load_op    = 1'b0;
    rslt       = 8'h77;
    dmdataout  = 8'h00;
    #2;
    chk_all("rst_async");
    repeat (2) @(posedge clk);
    #1;
    chk_all("rst_held_wr");
    reg_wr_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;

    chk_read(3'd0, 3'd1, "rd01");
    chk_read(3'd2, 3'd3, "rd23");
    chk_read(3'd4, 3'd5, "rd45");
    chk_read(3'd6, 3'd7, "rd67");

    // ALU writes to even registers.
    do_write(1'b0, 3'd0, 8'h00, 8'h00); exp_rf[0] = 8'h00; chk_all("alu0");
    do_write(1'b0, 3'd2, 8'h22, 8'h00); exp_rf[2] = 8'h22; chk_all("alu2");
    do_write(1'b0, 3'd4, 8'h44, 8'h00); exp_rf[4] = 8'h44; chk_all("alu4");
    do_write(1'b0, 3'd6, 8'h66, 8'h00); exp_rf[6] = 8'h66; chk_all("alu6");

    // Load writes to odd registers; rslt held at 00 so a wrong mux shows up.
    do_write(1'b1, 3'd1, 8'h00, 8'h11); exp_rf[1] = 8'h11; chk_all("ld1");
    do_write(1'b1, 3'd3, 8'h00, 8'h33); exp_rf[3] = 8'h33; chk_all("ld3");
    do_write(1'b1, 3'd5, 8'h00, 8'h55); exp_rf[5] = 8'h55; chk_all("ld5");
    do_write(1'b1, 3'd7, 8'h00, 8'h77); exp_rf[7] = 8'h77; chk_all("ld7");

    // Write to a non-default value on r0 (no hardwired zero).
    do_write(1'b0, 3'd0, 8'hE1, 8'h3C); exp_rf[0] = 8'hE1; chk_all("alu0_nz");

    // Write disabled across several edges.
    @(negedge clk);
    reg_wr_vld = 1'b0;
    dst        = 3'd4;
    rslt       = 8'h5A;
    load_op    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("wr_dis");

    // Read/write collision on r3 via both ports.
    @(negedge clk);
    opnda_addr = 3'd3;
    opndb_addr = 3'd3;
    dst        = 3'd3;
    load_op    = 1'b0;
    rslt       = 8'h9C;
    reg_wr_vld = 1'b1;
    #1;
    chk("coll_pre_a", oprnd_a, 8'h33);
    chk("coll_pre_b", oprnd_b, 8'h33);
    @(posedge clk);
    #1;
    reg_wr_vld = 1'b0;
    exp_rf[3]  = 8'h9C;
    chk("coll_post_a", oprnd_a, 8'h9C);
    chk("coll_post_b", oprnd_b, 8'h9C);
    chk_all("coll_all");

    // Async reset mid-cycle with a pending write.
    do_write(1'b0, 3'd5, 8'hF0, 8'h00); exp_rf[5] = 8'hF0; chk_all("pre_rst");
    @(negedge clk);
    reg_wr_vld = 1'b1;
    dst        = 3'd0;
    rslt       = 8'hEE;
    #2;
    rst_n = 1'b1;
    #1;
    exp_rf = rst_tbl;
    chk("rst_mid_r5", regfile5, 8'hAA);
    chk_all("rst_mid");
    @(posedge clk);
    #1;
    chk_all("rst_mid_wr_lost");
    @(negedge clk);
    rst_n = 1'b0;
    reg_wr_vld = 1'b0;

    // First write after reset release lands on the next edge.
    do_write(1'b1, 3'd6, 8'h00, 8'hB4); exp_rf[6] = 8'hB4; chk_all("post_rst_wr");
    chk_read(3'd6, 3'd5, "post_rst_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
